onehot_decoder_seq: RTL



---
 rtl/decoder_pkg.sv | 23 ++
 rtl/onehot_decoder_seq_decode.sv | 25 ++
 rtl/onehot_decoder_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
//   state_t      : controller states (IDLE / DIRECT / SCAN)
//   mode_t       : encoding of the 'mode' input
//   inactive_val : value of every y bit when no output is selected
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

  // Inactive level of a y bit: 0 for active-high outputs, 1 for active-low.
  function automatic logic inactive_val(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/onehot_decoder_seq_decode.sv
// Combinational N -> 2^N one-hot decoder with selectable output polarity.
// Parameters:
//   N          : select width
//   ACTIVE_LOW : 1 drives the selected bit low and all others high
// Ports:
//   sel : select index
//   y   : one-hot (or one-cold when ACTIVE_LOW=1) result
module onehot_decode #(
  parameter int N          = 3,
  parameter int ACTIVE_LOW = 0
) (
  input  logic [N-1:0]      sel,
  output logic [(1<<N)-1:0] y
);

  localparam int W = 1 << N;

  logic [W-1:0] hot;

  always_comb begin
    hot = W'(1) << sel;
    y   = (ACTIVE_LOW != 0) ? ~hot : hot;
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered N -> 2^N one-hot decoder with enable, direct mode and auto-scan.
//   Direct mode: y <= decode(a), idx <= a, one cycle of latency.
//   Scan mode  : starting at a, the selected position advances every
//                SCAN_DIV cycles and wraps modulo 2^N; 'wrap' pulses for the
//                first cycle of idx=0 after a wrap.
// Parameters:
//   N          : select width (y is 2^N wide), >= 1
//   SCAN_DIV   : dwell cycles per position in scan mode, >= 1
//   ACTIVE_LOW : 1 inverts y (selected bit 0, others 1)
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   en    : enable; low forces y inactive and returns to IDLE
//   mode  : 0 direct, 1 scan
//   a     : direct select / scan start index
//   y     : registered one-hot output
//   idx   : registered index currently shown on y
//   wrap  : one-cycle pulse when the scan index wraps 2^N-1 -> 0
// Build option:
//   DECODER_BLANK_EN : when defined, y is inactive for the first cycle of
//                      every scan step (not the scan entry); needs SCAN_DIV >= 2.
module onehot_decoder_seq
  import decoder_pkg::*;
#(
  parameter int N          = 3,
  parameter int SCAN_DIV   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      a,
  output logic [(1<<N)-1:0] y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W  = 1 << N;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

`ifdef DECODER_BLANK_EN
  localparam bit BLANK = 1'b1;
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("onehot_decoder_seq: DECODER_BLANK_EN requires SCAN_DIV >= 2");
  end
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [W-1:0] Y_INACTIVE = {W{inactive_val(ACTIVE_LOW)}};

  state_t          state_q, state_nxt;
  logic [N-1:0]    idx_q, idx_nxt;
  logic [DW-1:0]   dwell_q, dwell_nxt;
  logic [W-1:0]    y_q, y_nxt;
  logic            wrap_q, wrap_nxt;
  logic            show;
  logic [W-1:0]    dec_y;
  mode_t           mode_m;

  assign mode_m = mode_t'(mode);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; en has priority over mode
  always_comb begin
    state_nxt = state_q;
    if (!en) begin
      state_nxt = IDLE;
    end else if (mode_m == MODE_DIRECT) begin
      state_nxt = DIRECT;
    end else begin
      state_nxt = SCAN;
    end
  end

  // Output / datapath next values. The decoder looks at the next index so
  // y and idx always change on the same edge.
  always_comb begin
    idx_nxt   = idx_q;
    dwell_nxt = '0;
    wrap_nxt  = 1'b0;
    show      = 1'b0;
    if (en) begin
      if (mode_m == MODE_DIRECT || state_q != SCAN) begin
        // Direct load, or scan entry (never blanked)
        idx_nxt = a;
        show    = 1'b1;
      end else if (dwell_q == DWELL_LAST) begin
        idx_nxt  = idx_q + N'(1);
        wrap_nxt = (idx_q == '1);
        show     = !BLANK;
      end else begin
        dwell_nxt = dwell_q + DW'(1);
        show      = 1'b1;
      end
    end
    y_nxt = show ? dec_y : Y_INACTIVE;
  end

  onehot_decode #(
    .N          (N),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_decode (
    .sel (idx_nxt),
    .y   (dec_y)
  );

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      dwell_q <= '0;
      y_q     <= Y_INACTIVE;
      wrap_q  <= 1'b0;
    end else begin
      idx_q   <= idx_nxt;
      dwell_q <= dwell_nxt;
      y_q     <= y_nxt;
      wrap_q  <= wrap_nxt;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
